axi_master_bridge: RTL and testbench

- AXI4 master that turns single core/cache memory requests into INCR bursts on a 64-bit AXI bus.
- Drives the full-AXI slave memory model in simulation, and later the SoC crossbar.
- One outstanding transaction at a time, read or write.
- Core side is a simple valid/ready request port plus a write-data stream and a response stream.

---
 rtl/axi_master_bridge_pkg.sv | 39 +++
 rtl/axi_master_bridge_if.sv | 74 +++++++
 rtl/axi_master_bridge.sv | 163 ++++++++++++++++
 tb/tb_axi_master_bridge.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_master_bridge_pkg.sv
// Purpose: AXI4 constants, bridge FSM state codes and the request legality check.
// Latency: none, declarations and a pure function only.
// Backpressure: not applicable.
package axi_master_bridge_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int ID_W   = 4;
  localparam int LEN_W  = 8;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // State codes are plain constants so older tooling and netlist dumps stay readable.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_AR   = 3'd1;
  localparam state_t ST_R    = 3'd2;
  localparam state_t ST_AW   = 3'd3;
  localparam state_t ST_W    = 3'd4;
  localparam state_t ST_B    = 3'd5;
  localparam state_t ST_ERR  = 3'd6;

  // A request is rejected when the beat is wider than the 64-bit bus or the
  // start address is not aligned to the beat size.
  function automatic logic req_bad(input logic [2:0] addr_lo, input logic [2:0] size);
    case (size)
      3'd0:    req_bad = 1'b0;
      3'd1:    req_bad = addr_lo[0];
      3'd2:    req_bad = |addr_lo[1:0];
      3'd3:    req_bad = |addr_lo;
      default: req_bad = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/axi_master_bridge_if.sv
// Purpose: AXI4 five-channel bundle between the bridge (master) and memory or crossbar (slave).
// Latency: none, wires only.
// Backpressure: standard AXI valid/ready on every channel.
interface axi_master_bridge_if;
  import axi_master_bridge_pkg::*;

  logic [ADDR_W-1:0] araddr;
  logic [LEN_W-1:0]  arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [ID_W-1:0]   arid;
  logic [1:0]        arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  logic [ADDR_W-1:0] awaddr;
  logic [LEN_W-1:0]  awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic [ID_W-1:0]   awid;
  logic [1:0]        awlock;
  logic [3:0]        awcache;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;

  logic [ID_W-1:0]   wid;
  logic [DATA_W-1:0] wdata;
  logic [7:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arlen, arsize, arburst, arid, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awaddr, awlen, awsize, awburst, awid, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arid, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awaddr, awlen, awsize, awburst, awid, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/axi_master_bridge.sv
// Purpose: turns one core memory request at a time into a single AXI4 INCR burst.
// Latency: read beats and the write response reach rsp_* one cycle after the bus beat.
// Backpressure: req_ready only in IDLE; write data passes straight through to wvalid/wready.
module axi_master_bridge
  import axi_master_bridge_pkg::*;
#(
  parameter logic [ID_W-1:0] AXI_ID = 4'd0
) (
  input  logic              aclk,
  input  logic              aresetn,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [2:0]        req_size,

  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wd_data,
  input  logic [7:0]        wd_strb,

  output logic              rsp_valid,
  output logic              rsp_last,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_data,

  axi_master_bridge_if.master axi
);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [2:0]        size_q;
  logic [LEN_W-1:0]  cnt;
  logic              err_q;

  logic len_hit;
  logic r_last_beat;
  logic r_err_nxt;
  logic w_fire;

  assign len_hit     = (cnt == len_q);
  // The burst ends on whichever comes first: the slave's rlast or our own count.
  assign r_last_beat = axi.rlast | len_hit;
  assign r_err_nxt   = err_q
                     | (axi.rresp != RESP_OKAY)
                     | (axi.rid != AXI_ID)
                     | (axi.rlast != len_hit);
  assign w_fire      = axi.wvalid & axi.wready;

  assign req_ready   = (state == ST_IDLE);

  assign axi.araddr  = addr_q;
  assign axi.arlen   = len_q;
  assign axi.arsize  = size_q;
  assign axi.arburst = BURST_INCR;
  assign axi.arid    = AXI_ID;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'b0000;
  assign axi.arprot  = 3'b000;
  assign axi.arvalid = (state == ST_AR);
  assign axi.rready  = (state == ST_R);

  assign axi.awaddr  = addr_q;
  assign axi.awlen   = len_q;
  assign axi.awsize  = size_q;
  assign axi.awburst = BURST_INCR;
  assign axi.awid    = AXI_ID;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'b0000;
  assign axi.awprot  = 3'b000;
  assign axi.awvalid = (state == ST_AW);

  // Write data is a pure pass-through gated by the W state, so no beat can leave before AW.
  assign axi.wid     = AXI_ID;
  assign axi.wdata   = wd_data;
  assign axi.wstrb   = wd_strb;
  assign axi.wlast   = len_hit;
  assign axi.wvalid  = (state == ST_W) & wd_valid;
  assign wd_ready    = (state == ST_W) & axi.wready;
  assign axi.bready  = (state == ST_B);

  // Request latch, FSM, beat counter, sticky error and the registered response port.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      cnt       <= '0;
      err_q     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q <= req_addr;
            len_q  <= req_len;
            size_q <= req_size;
            err_q  <= 1'b0;
            if (req_bad(req_addr[2:0], req_size)) state <= ST_ERR;
            else if (req_wen)                     state <= ST_AW;
            else                                  state <= ST_AR;
          end
        end
        ST_ERR: begin
          rsp_valid <= 1'b1;
          rsp_last  <= 1'b1;
          rsp_err   <= 1'b1;
          state     <= ST_IDLE;
        end
        ST_AR: begin
          if (axi.arready) begin
            cnt   <= '0;
            state <= ST_R;
          end
        end
        ST_R: begin
          if (axi.rvalid) begin
            rsp_valid <= 1'b1;
            rsp_data  <= axi.rdata;
            rsp_last  <= r_last_beat;
            rsp_err   <= r_last_beat & r_err_nxt;
            err_q     <= r_err_nxt;
            cnt       <= cnt + 1'b1;
            if (r_last_beat) state <= ST_IDLE;
          end
        end
        ST_AW: begin
          if (axi.awready) begin
            cnt   <= '0;
            state <= ST_W;
          end
        end
        ST_W: begin
          if (w_fire) begin
            cnt <= cnt + 1'b1;
            if (len_hit) state <= ST_B;
          end
        end
        ST_B: begin
          if (axi.bvalid) begin
            rsp_valid <= 1'b1;
            rsp_last  <= 1'b1;
            rsp_err   <= (axi.bresp != RESP_OKAY) | (axi.bid != AXI_ID);
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_master_bridge.sv
// Purpose: directed bench for axi_master_bridge with a transaction-level response model.
// Latency: expected responses are queued per request and matched in order as they appear.
// Backpressure: the bench plays the AXI slave, with programmable ready delays and data gaps.
module tb_axi_master_bridge;
  import axi_master_bridge_pkg::*;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic [2:0]  req_size;
  logic        wd_valid, wd_ready;
  logic [63:0] wd_data;
  logic [7:0]  wd_strb;
  logic        rsp_valid, rsp_last, rsp_err;
  logic [63:0] rsp_data;

  axi_master_bridge_if bus();

  axi_master_bridge #(.AXI_ID(4'd0)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_len(req_len), .req_size(req_size),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .rsp_valid(rsp_valid), .rsp_last(rsp_last), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .axi(bus)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk_v(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    chk_v(name, 64'(act), 64'(exp));
  endtask

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {~a, a};
  endfunction

  // Every response the bridge emits must match the next queued expectation.
  always @(negedge aclk) begin : cmp
    rsp_t e;
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk_b("rsp_unexpected", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk_v("rsp_data", rsp_data, e.data);
        chk_b("rsp_last", rsp_last, e.last);
        chk_b("rsp_err", rsp_err, e.err);
      end
    end
  end

  function automatic logic sig(input int w);
    case (w)
      0:       return bus.arvalid;
      1:       return bus.awvalid;
      2:       return bus.bready;
      default: return req_ready;
    endcase
  endfunction

  // Returns sitting on a negedge with the selected signal high, or records a timeout.
  task automatic wait_hi(input int w, input string name);
    for (int c = 0; c < 50; c++) begin
      @(negedge aclk);
      if (sig(w)) return;
      @(posedge aclk); #1;
    end
    chk_b(name, 1'b0, 1'b1);
  endtask

  task automatic send_req(input logic wen, input logic [31:0] addr,
                          input logic [7:0] len, input logic [2:0] size);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_len = len; req_size = size;
    wait_hi(3, "req_timeout");
    @(posedge aclk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (3) @(negedge aclk);
    chk_v(name, 64'(exp_q.size()), 64'd0);
    chk_b("idle_after", req_ready, 1'b1);
    @(posedge aclk); #1;
  endtask

  // rl_at: beat index where the slave raises rlast (-1 = on beat len); resp_at: SLVERR beat.
  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input int ar_delay, input int rl_at, input int resp_at,
                         input logic use_lit, input logic [63:0] lit);
    logic [63:0] bd[256];
    logic        bl[256];
    logic [1:0]  br[256];
    logic [63:0] dat;
    logic        rl, lastb, err;
    logic [1:0]  rs;
    rsp_t        e;
    int          nb;
    err = 1'b0; nb = 0;
    for (int i = 0; i <= int'(len); i++) begin
      rl    = (rl_at < 0) ? (i == int'(len)) : (i == rl_at);
      rs    = (i == resp_at) ? RESP_SLVERR : RESP_OKAY;
      dat   = (use_lit && i == 0) ? lit : mem_word(addr + (32'(i) << size));
      lastb = rl || (i == int'(len));
      err   = err | (rs != RESP_OKAY) | (rl != (i == int'(len)));
      bd[nb] = dat; bl[nb] = rl; br[nb] = rs; nb++;
      e.data = dat; e.last = lastb; e.err = lastb & err;
      exp_q.push_back(e);
      if (lastb) break;
    end
    send_req(1'b0, addr, len, size);
    wait_hi(0, "ar_timeout");
    for (int d = 0; d < ar_delay; d++) begin
      chk_b("arvalid_hold", bus.arvalid, 1'b1);
      chk_v("araddr_hold", 64'(bus.araddr), 64'(addr));
      @(posedge aclk); #1;
      @(negedge aclk);
    end
    bus.arready = 1'b1;
    chk_b("arvalid", bus.arvalid, 1'b1);
    chk_b("awvalid_on_read", bus.awvalid, 1'b0);
    chk_v("araddr", 64'(bus.araddr), 64'(addr));
    chk_v("arlen", 64'(bus.arlen), 64'(len));
    chk_v("arsize", 64'(bus.arsize), 64'(size));
    chk_v("arburst", 64'(bus.arburst), 64'd1);
    chk_v("arid", 64'(bus.arid), 64'd0);
    @(posedge aclk); #1;
    bus.arready = 1'b0;
    for (int i = 0; i < nb; i++) begin
      bus.rvalid = 1'b1; bus.rdata = bd[i]; bus.rlast = bl[i]; bus.rresp = br[i]; bus.rid = 4'd0;
      @(negedge aclk);
      chk_b("rready", bus.rready, 1'b1);
      @(posedge aclk); #1;
    end
    bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.rresp = 2'b00;
    drain("read_rsp_count");
  endtask

  // gap: one idle cycle before beat 1; rst_at: beat index at which aresetn is pulsed (-1 = never).
  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic gap,
                          input logic [3:0] bid_v, input logic [1:0] bresp_v, input int rst_at);
    rsp_t e;
    wd_valid = 1'b1; wd_data = mem_word(addr); wd_strb = 8'hFF;
    bus.wready = 1'b1;
    send_req(1'b1, addr, len, 3'd3);
    wait_hi(1, "aw_timeout");
    chk_b("w_before_aw", bus.wvalid, 1'b0);
    chk_b("wd_ready_before_aw", wd_ready, 1'b0);
    @(posedge aclk); #1;
    @(negedge aclk);
    chk_b("awvalid_hold", bus.awvalid, 1'b1);
    chk_b("w_before_aw2", bus.wvalid, 1'b0);
    bus.awready = 1'b1;
    chk_v("awaddr", 64'(bus.awaddr), 64'(addr));
    chk_v("awlen", 64'(bus.awlen), 64'(len));
    chk_v("awsize", 64'(bus.awsize), 64'd3);
    chk_v("awburst", 64'(bus.awburst), 64'd1);
    chk_v("awid", 64'(bus.awid), 64'd0);
    @(posedge aclk); #1;
    bus.awready = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (gap && i == 1) begin
        wd_valid = 1'b0;
        @(negedge aclk);
        chk_b("w_gap", bus.wvalid, 1'b0);
        @(posedge aclk); #1;
      end
      wd_valid = 1'b1;
      wd_data  = mem_word(addr + 32'(8 * i));
      wd_strb  = (i == 1) ? 8'h0F : 8'hFF;
      if (i == rst_at) begin
        aresetn = 1'b0;
        @(posedge aclk); #1;
        @(negedge aclk);
        chk_b("rst_wvalid", bus.wvalid, 1'b0);
        chk_b("rst_awvalid", bus.awvalid, 1'b0);
        chk_b("rst_wd_ready", wd_ready, 1'b0);
        chk_b("rst_rsp_valid", rsp_valid, 1'b0);
        aresetn = 1'b1; wd_valid = 1'b0; bus.wready = 1'b0;
        @(posedge aclk); #1;
        @(negedge aclk);
        chk_b("rst_req_ready", req_ready, 1'b1);
        drain("rst_no_rsp");
        return;
      end
      @(negedge aclk);
      chk_b("wvalid", bus.wvalid, 1'b1);
      chk_b("wd_ready", wd_ready, 1'b1);
      chk_v("wdata", bus.wdata, mem_word(addr + 32'(8 * i)));
      chk_v("wstrb", 64'(bus.wstrb), (i == 1) ? 64'h0F : 64'hFF);
      chk_b("wlast", bus.wlast, i == int'(len));
      @(posedge aclk); #1;
    end
    wd_valid = 1'b0; bus.wready = 1'b0;
    e.data = 64'h0; e.last = 1'b1; e.err = (|bresp_v) | (|bid_v);
    exp_q.push_back(e);
    bus.bvalid = 1'b1; bus.bid = bid_v; bus.bresp = bresp_v;
    wait_hi(2, "b_timeout");
    @(posedge aclk); #1;
    bus.bvalid = 1'b0; bus.bid = 4'd0; bus.bresp = 2'b00;
    drain("write_rsp_count");
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rsp_t e;
    req_valid = 0; req_wen = 0; req_addr = '0; req_len = '0; req_size = '0;
    wd_valid = 0; wd_data = '0; wd_strb = '0;
    bus.arready = 0; bus.rid = '0; bus.rdata = '0; bus.rresp = '0; bus.rlast = 0; bus.rvalid = 0;
    bus.awready = 0; bus.wready = 0; bus.bid = '0; bus.bresp = '0; bus.bvalid = 0;

    // Reset state
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk_b("reset_arvalid", bus.arvalid, 1'b0);
    chk_b("reset_awvalid", bus.awvalid, 1'b0);
    chk_b("reset_wvalid", bus.wvalid, 1'b0);
    chk_b("reset_rready", bus.rready, 1'b0);
    chk_b("reset_bready", bus.bready, 1'b0);
    chk_b("reset_wd_ready", wd_ready, 1'b0);
    chk_b("reset_rsp_valid", rsp_valid, 1'b0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    chk_b("reset_req_ready", req_ready, 1'b1);
    @(posedge aclk); #1;

    // Single-beat read with literal data
    do_read(32'h8000_0000, 8'd0, 3'd3, 0, -1, -1, 1'b1, 64'h1122_3344_5566_7788);
    // Four-beat read behind a slow arready
    do_read(32'h8000_0100, 8'd3, 3'd3, 2, -1, -1, 1'b0, 64'h0);
    // Two-beat write with a data gap and partial strobe on beat 1
    do_write(32'h8000_0200, 8'd1, 1'b1, 4'd0, 2'b00, -1);
    // Early rlast on the second beat of a four-beat read
    do_read(32'h8000_0300, 8'd3, 3'd3, 0, 1, -1, 1'b0, 64'h0);
    // SLVERR on the first beat stays sticky to the final beat
    do_read(32'h8000_0400, 8'd1, 3'd3, 0, -1, 0, 1'b0, 64'h0);

    // Misaligned request: no bus activity, error response two cycles after acceptance
    e.data = 64'h0; e.last = 1'b1; e.err = 1'b1;
    exp_q.push_back(e);
    send_req(1'b0, 32'h8000_0004, 8'd0, 3'd3);
    @(negedge aclk);
    chk_b("misalign_rsp_early", rsp_valid, 1'b0);
    chk_b("misalign_arvalid", bus.arvalid, 1'b0);
    chk_b("misalign_awvalid", bus.awvalid, 1'b0);
    @(posedge aclk); #1;
    @(negedge aclk);
    chk_b("misalign_rsp_valid", rsp_valid, 1'b1);
    chk_b("misalign_arvalid2", bus.arvalid, 1'b0);
    @(posedge aclk); #1;
    drain("misalign_rsp_count");

    // Oversized beat is rejected the same way
    e.data = 64'h0; e.last = 1'b1; e.err = 1'b1;
    exp_q.push_back(e);
    send_req(1'b1, 32'h0000_0000, 8'd0, 3'd4);
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      chk_b("size4_awvalid", bus.awvalid, 1'b0);
      @(posedge aclk); #1;
    end
    drain("size4_rsp_count");

    // 4-byte aligned 4-byte read is legal
    do_read(32'h0000_0004, 8'd0, 3'd2, 1, -1, -1, 1'b0, 64'h0);
    // Write response with a foreign bid is an error
    do_write(32'h8000_0500, 8'd0, 1'b0, 4'd3, 2'b00, -1);
    // Reset in the middle of an eight-beat write
    do_write(32'h8000_0600, 8'd7, 1'b0, 4'd0, 2'b00, 3);
    // Maximum burst: 256 beats without a counter-wrap error
    do_read(32'h8000_1000, 8'd255, 3'd3, 0, -1, -1, 1'b0, 64'h0);

    repeat (2) @(posedge aclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
